serial_mem_slave_ml: RTL and testbench



---
 rtl/serial_mem_slave_ml.sv | 200 ++++++++++++++++++++
 tb/tb_serial_mem_slave_ml.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mem_slave_ml.sv
// Multi-lane serial memory slave: decodes a serial control frame, then serves
// single or burst word reads/writes of an internal RAM over LANES data lines.
module serial_mem_slave_ml #(
    parameter int ADDR_DEPTH    = 2000,
    parameter int DATA_WIDTH    = 32,
    parameter int LANES         = 1,
    parameter int SLAVES        = 3,
    parameter int S_ID_WIDTH    = $clog2(SLAVES + 1),
    parameter int SLAVEID       = 1,
    parameter     MEM_INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             control,
    input  logic [LANES-1:0] wD,
    input  logic             valid,
    input  logic             last,
    output logic [LANES-1:0] rD,
    output logic             ready,
    output logic             err,
    output logic [2:0]       dbg_state
);

    localparam int ADDR_WIDTH = $clog2(ADDR_DEPTH);
    localparam int BEATS      = DATA_WIDTH / LANES;
    localparam int CFG_LEN    = 3 + S_ID_WIDTH + 2 + ADDR_WIDTH;
    localparam int CW         = $clog2(CFG_LEN + 1);
    localparam int BW         = $clog2(BEATS + 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH + 1)'(ADDR_DEPTH);

    // Beat handshake: a beat moves on a rising clk edge where both valid and
    // ready are high; in READ, valid means the master took the beat on rD.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CFG    = 3'd1,
        DECODE = 3'd2,
        FETCH  = 3'd3,
        READ   = 3'd4,
        WRITE  = 3'd5,
        COMMIT = 3'd6
    } state_t;

    state_t                  state, state_nxt;
    logic [CFG_LEN-1:0]      cfg_sr;
    logic [CW-1:0]           cfg_cnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    burst_q;
    logic                    last_q;
    logic                    fetch_ph;
    logic [BW-1:0]           beat_cnt;
    logic [DATA_WIDTH-1:0]   rd_buf;
    logic [DATA_WIDTH-1:0]   wr_buf;
    logic [DATA_WIDTH-1:0]   ram_q;
    logic [DATA_WIDTH-1:0]   ram [ADDR_DEPTH];

    logic [2:0]              f_start;
    logic [S_ID_WIDTH-1:0]   f_id;
    logic                    f_rw;
    logic                    f_burst;
    logic [ADDR_WIDTH-1:0]   f_addr;
    logic                    id_match;
    logic                    in_range;
    logic                    cfg_done;
    logic                    beat_done;
    logic [ADDR_WIDTH-1:0]   addr_inc;
    logic                    ram_re;
    logic [ADDR_WIDTH-1:0]   ram_raddr;

    assign f_start   = cfg_sr[CFG_LEN-1 -: 3];
    assign f_id      = cfg_sr[CFG_LEN-4 -: S_ID_WIDTH];
    assign f_rw      = cfg_sr[ADDR_WIDTH+1];
    assign f_burst   = cfg_sr[ADDR_WIDTH];
    assign f_addr    = cfg_sr[ADDR_WIDTH-1:0];
    assign id_match  = (f_start == 3'b111) && (f_id == S_ID_WIDTH'(SLAVEID));
    assign in_range  = {1'b0, f_addr} < DEPTH_V;
    assign cfg_done  = (cfg_cnt == CW'(CFG_LEN - 1));
    assign beat_done = valid && (beat_cnt == BW'(BEATS - 1));
    assign addr_inc  = (addr == ADDR_WIDTH'(ADDR_DEPTH - 1)) ? '0 : addr + ADDR_WIDTH'(1);

    // A continued burst read spends one FETCH cycle issuing the RAM read and
    // one loading rd_buf, giving the two-cycle ready gap between words.
    assign ram_re    = ((state == DECODE) && id_match && in_range && !f_rw) ||
                       ((state == FETCH) && !fetch_ph);
    assign ram_raddr = (state == DECODE) ? f_addr : addr;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (control) state_nxt = CFG;
            CFG:     if (cfg_done) state_nxt = DECODE;
            DECODE: begin
                if (id_match && in_range) state_nxt = f_rw ? WRITE : FETCH;
                else                      state_nxt = IDLE;
            end
            FETCH:   if (fetch_ph) state_nxt = READ;
            READ: begin
                if (beat_done) state_nxt = (!burst_q || last) ? IDLE : FETCH;
            end
            WRITE:   if (beat_done) state_nxt = COMMIT;
            COMMIT:  state_nxt = (!burst_q || last_q) ? IDLE : WRITE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready     = 1'b1;
        err       = 1'b0;
        rD        = rd_buf[DATA_WIDTH-1 -: LANES];
        dbg_state = state;
        case (state)
            DECODE: begin
                if (id_match && in_range && !f_rw) ready = 1'b0;
                if (id_match && !in_range)         err   = 1'b1;
            end
            FETCH:   ready = 1'b0;
            COMMIT:  ready = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cfg_sr   <= '0;
            cfg_cnt  <= '0;
            addr     <= '0;
            burst_q  <= 1'b0;
            last_q   <= 1'b0;
            fetch_ph <= 1'b0;
            beat_cnt <= '0;
            rd_buf   <= '0;
            wr_buf   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (control) begin
                        cfg_sr  <= CFG_LEN'(1);
                        cfg_cnt <= CW'(1);
                    end
                end
                CFG: begin
                    cfg_sr  <= {cfg_sr[CFG_LEN-2:0], control};
                    cfg_cnt <= cfg_cnt + CW'(1);
                end
                DECODE: begin
                    addr     <= f_addr;
                    burst_q  <= f_burst;
                    beat_cnt <= '0;
                    fetch_ph <= 1'b1;
                    cfg_cnt  <= '0;
                end
                FETCH: begin
                    fetch_ph <= 1'b1;
                    if (fetch_ph) begin
                        rd_buf   <= ram_q;
                        beat_cnt <= '0;
                    end
                end
                READ: begin
                    if (valid) begin
                        rd_buf   <= rd_buf << LANES;
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                    if (beat_done) begin
                        beat_cnt <= '0;
                        if (burst_q && !last) begin
                            addr     <= addr_inc;
                            fetch_ph <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (valid) begin
                        wr_buf   <= (wr_buf << LANES) | DATA_WIDTH'(wD);
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                    if (beat_done) begin
                        beat_cnt <= '0;
                        last_q   <= last;
                    end
                end
                COMMIT: begin
                    if (burst_q && !last_q) addr <= addr_inc;
                end
                default: ;
            endcase
        end
    end

    // RAM array and its registered read port carry no reset.
    always_ff @(posedge clk) begin
        if (state == COMMIT) ram[addr] <= wr_buf;
        if (ram_re)          ram_q     <= ram[ram_raddr];
    end

endmodule

// File: tb/tb_serial_mem_slave_ml.sv
// Directed bench for serial_mem_slave_ml: a 1-lane and a 4-lane instance,
// a table of single-word frames plus burst, stall and reset sequences.
module tb_serial_mem_slave_ml;

    logic       clk = 1'b0;
    logic       rstN;
    logic       control1, valid1, last1, ready1, err1;
    logic [0:0] wD1, rD1;
    logic [2:0] dbg1;
    logic       control4, valid4, last4, ready4, err4;
    logic [3:0] wD4, rD4;
    logic [2:0] dbg4;

    int total  = 0;
    int passed = 0;

    serial_mem_slave_ml #(.LANES(1)) u_dut1 (
        .clk(clk), .rstN(rstN), .control(control1), .wD(wD1), .valid(valid1),
        .last(last1), .rD(rD1), .ready(ready1), .err(err1), .dbg_state(dbg1)
    );

    serial_mem_slave_ml #(.LANES(4)) u_dut4 (
        .clk(clk), .rstN(rstN), .control(control4), .wD(wD4), .valid(valid4),
        .last(last4), .rD(rD4), .ready(ready4), .err(err4), .dbg_state(dbg4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  start;
        logic [1:0]  id;
        logic        rw;
        logic [10:0] addr;
        logic [31:0] data;
        logic        exp_err;
        logic        serve;
    } vec_t;

    localparam int NV = 13;
    vec_t vt[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic rdy_of(input bit s);
        return s ? ready4 : ready1;
    endfunction

    function automatic logic [3:0] rd_of(input bit s);
        return s ? rD4 : {3'b000, rD1};
    endfunction

    task automatic set_in(input bit s, input logic v, input logic l, input logic [3:0] wd);
        if (s) begin valid4 = v; last4 = l; wD4 = wd; end
        else begin valid1 = v; last1 = l; wD1 = wd[0:0]; end
    endtask

    task automatic drive_ctl(input bit s, input logic b);
        if (s) control4 = b;
        else   control1 = b;
    endtask

    function automatic logic [3:0] beat_of(input bit s, input logic [31:0] data, input int b);
        logic [31:0] t;
        int ln;
        ln = s ? 4 : 1;
        t  = data >> (32 - ln * (b + 1));
        return s ? t[3:0] : {3'b000, t[0]};
    endfunction

    // Ends at the negedge where the slave sits in DECODE.
    task automatic send_frame(input bit s, input logic [2:0] st, input logic [1:0] id,
                              input logic rw, input logic burst, input logic [10:0] a);
        logic [17:0] f;
        f = {st, id, rw, burst, a};
        for (int i = 17; i >= 0; i--) begin
            @(negedge clk);
            drive_ctl(s, f[i]);
        end
        @(negedge clk);
        drive_ctl(s, 1'b0);
    endtask

    // Ends at the negedge of the COMMIT cycle.
    task automatic write_word(input bit s, input logic [31:0] data, input logic lastflag,
                              input logic last_mid);
        int beats;
        beats = s ? 8 : 32;
        for (int b = 0; b < beats; b++) begin
            @(negedge clk);
            check("wr_ready", 32'(rdy_of(s)), 32'd1);
            set_in(s, 1'b1, (b == beats - 1) ? lastflag : (last_mid && b == 0), beat_of(s, data, b));
        end
        @(negedge clk);
        set_in(s, 1'b0, 1'b0, 4'h0);
        check("commit_ready", 32'(rdy_of(s)), 32'd0);
    endtask

    // Starts at a READ negedge; ends at the negedge after the final beat.
    task automatic read_word(input bit s, input logic [31:0] data, input logic lastflag,
                             input bit toggle);
        int beats;
        beats = s ? 8 : 32;
        for (int b = 0; b < beats; b++) begin
            check("rd_ready", 32'(rdy_of(s)), 32'd1);
            check("rd_beat", 32'(rd_of(s)), 32'(beat_of(s, data, b)));
            if (toggle) begin
                set_in(s, 1'b0, 1'b0, 4'h0);
                @(negedge clk);
                check("rd_hold", 32'(rd_of(s)), 32'(beat_of(s, data, b)));
            end
            set_in(s, 1'b1, (b == beats - 1) && lastflag, 4'h0);
            @(negedge clk);
        end
        set_in(s, 1'b0, 1'b0, 4'h0);
    endtask

    // From the DECODE negedge of a matched read: two ready-low cycles, then data.
    task automatic do_read(input bit s, input logic [31:0] data);
        @(negedge clk);
        check("fetch_ready", 32'(rdy_of(s)), 32'd0);
        @(negedge clk);
        read_word(s, data, 1'b0, 1'b0);
        check("read_idle_ready", 32'(rdy_of(s)), 32'd1);
    endtask

    task automatic burst_gap(input bit s);
        check("gap1_ready", 32'(rdy_of(s)), 32'd0);
        @(negedge clk);
        check("gap2_ready", 32'(rdy_of(s)), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        vt[0]  = '{3'b111, 2'd1, 1'b1, 11'd5,    32'hA5A5_0F0F, 1'b0, 1'b1};
        vt[1]  = '{3'b111, 2'd1, 1'b0, 11'd5,    32'hA5A5_0F0F, 1'b0, 1'b1};
        vt[2]  = '{3'b111, 2'd1, 1'b1, 11'd0,    32'h1234_5678, 1'b0, 1'b1};
        vt[3]  = '{3'b111, 2'd1, 1'b1, 11'd1999, 32'hDEAD_BEEF, 1'b0, 1'b1};
        vt[4]  = '{3'b111, 2'd2, 1'b1, 11'd0,    32'hFFFF_FFFF, 1'b0, 1'b0};
        vt[5]  = '{3'b111, 2'd1, 1'b0, 11'd0,    32'h1234_5678, 1'b0, 1'b1};
        vt[6]  = '{3'b111, 2'd1, 1'b0, 11'd2040, 32'h0,         1'b1, 1'b0};
        vt[7]  = '{3'b111, 2'd2, 1'b0, 11'd2040, 32'h0,         1'b0, 1'b0};
        vt[8]  = '{3'b111, 2'd1, 1'b0, 11'd1999, 32'hDEAD_BEEF, 1'b0, 1'b1};
        vt[9]  = '{3'b111, 2'd3, 1'b0, 11'd5,    32'h0,         1'b0, 1'b0};
        vt[10] = '{3'b111, 2'd1, 1'b1, 11'd2000, 32'h0,         1'b1, 1'b0};
        vt[11] = '{3'b111, 2'd0, 1'b1, 11'd5,    32'h0,         1'b0, 1'b0};
        vt[12] = '{3'b101, 2'd1, 1'b0, 11'd5,    32'h0,         1'b0, 1'b0};

        rstN = 1'b0;
        control1 = 1'b0; control4 = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 4'h0);
        set_in(1'b1, 1'b0, 1'b0, 4'h0);
        repeat (2) @(negedge clk);
        check("rst_ready1", 32'(ready1), 32'd1);
        check("rst_ready4", 32'(ready4), 32'd1);
        check("rst_rd4", 32'(rD4), 32'd0);
        check("rst_err4", 32'(err4), 32'd0);
        check("rst_state4", 32'(dbg4), 32'd0);
        rstN = 1'b1;

        // Table of single-word frames on the 4-lane slave.
        for (int i = 0; i < NV; i++) begin
            send_frame(1'b1, vt[i].start, vt[i].id, vt[i].rw, 1'b0, vt[i].addr);
            check("dec_err", 32'(err4), 32'(vt[i].exp_err));
            check("dec_ready", 32'(ready4), 32'(!(vt[i].serve && !vt[i].rw)));
            if (vt[i].serve && vt[i].rw) begin
                write_word(1'b1, vt[i].data, 1'b0, 1'b0);
                @(negedge clk);
                check("wr_idle_ready", 32'(ready4), 32'd1);
            end else if (vt[i].serve) begin
                do_read(1'b1, vt[i].data);
            end else begin
                @(negedge clk);
                check("skip_err", 32'(err4), 32'd0);
                check("skip_ready", 32'(ready4), 32'd1);
                check("skip_state", 32'(dbg4), 32'd0);
            end
        end

        // 1-lane single write then read-back of addr 5.
        send_frame(1'b0, 3'b111, 2'd1, 1'b1, 1'b0, 11'd5);
        check("l1_dec_ready", 32'(ready1), 32'd1);
        write_word(1'b0, 32'hA5A5_0F0F, 1'b0, 1'b0);
        @(negedge clk);
        check("l1_post_commit_ready", 32'(ready1), 32'd1);
        check("l1_post_commit_state", 32'(dbg1), 32'd0);
        send_frame(1'b0, 3'b111, 2'd1, 1'b0, 1'b0, 11'd5);
        check("l1_rd_dec_ready", 32'(ready1), 32'd0);
        do_read(1'b0, 32'hA5A5_0F0F);

        // Burst write of three words across the top-of-RAM wrap; last on a
        // non-final beat of the first word must be ignored.
        send_frame(1'b1, 3'b111, 2'd1, 1'b1, 1'b1, 11'd1998);
        write_word(1'b1, 32'h1111_1111, 1'b0, 1'b1);
        write_word(1'b1, 32'h2222_2222, 1'b0, 1'b0);
        write_word(1'b1, 32'h3333_3333, 1'b1, 1'b0);
        @(negedge clk);
        check("bw_idle_ready", 32'(ready4), 32'd1);
        check("bw_idle_state", 32'(dbg4), 32'd0);

        // Burst read back with valid toggling.
        send_frame(1'b1, 3'b111, 2'd1, 1'b0, 1'b1, 11'd1998);
        check("br_dec_ready", 32'(ready4), 32'd0);
        @(negedge clk);
        check("br_fetch_ready", 32'(ready4), 32'd0);
        @(negedge clk);
        read_word(1'b1, 32'h1111_1111, 1'b0, 1'b1);
        burst_gap(1'b1);
        read_word(1'b1, 32'h2222_2222, 1'b0, 1'b1);
        burst_gap(1'b1);
        read_word(1'b1, 32'h3333_3333, 1'b1, 1'b1);
        check("br_idle_ready", 32'(ready4), 32'd1);
        check("br_idle_state", 32'(dbg4), 32'd0);

        // Park the 4-lane slave mid-read, then reset both mid-transaction.
        send_frame(1'b1, 3'b111, 2'd1, 1'b0, 1'b0, 11'd5);
        repeat (2) @(negedge clk);
        check("park_rd", 32'(rD4), 32'hA);
        send_frame(1'b0, 3'b111, 2'd1, 1'b1, 1'b0, 11'd5);
        for (int b = 0; b < 10; b++) begin
            @(negedge clk);
            set_in(1'b0, 1'b1, 1'b0, beat_of(1'b0, 32'h0BAD_F00D, b));
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 4'h0);
        check("stall_rd_hold", 32'(rD4), 32'hA);
        check("stall_ready", 32'(ready4), 32'd1);
        rstN = 1'b0;
        #1;
        check("mid_rst_ready1", 32'(ready1), 32'd1);
        check("mid_rst_rd1", 32'(rD1), 32'd0);
        check("mid_rst_state1", 32'(dbg1), 32'd0);
        check("mid_rst_ready4", 32'(ready4), 32'd1);
        check("mid_rst_rd4", 32'(rD4), 32'd0);
        check("mid_rst_state4", 32'(dbg4), 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        send_frame(1'b0, 3'b111, 2'd1, 1'b0, 1'b0, 11'd5);
        check("post_rst_dec_ready1", 32'(ready1), 32'd0);
        do_read(1'b0, 32'hA5A5_0F0F);
        send_frame(1'b1, 3'b111, 2'd1, 1'b0, 1'b0, 11'd0);
        check("post_rst_dec_ready4", 32'(ready4), 32'd0);
        do_read(1'b1, 32'h3333_3333);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
